// File: rtl/sha256_serial_pkg.sv
// Shared types and constants for the SHA-256 serial host: state encoding,
// block/digest sizes and a counter-width helper.
package sha256_serial_pkg;

  localparam int SHA256_BLOCK_BITS  = 512;
  localparam int SHA256_DIGEST_BITS = 256;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT,
    RECV,
    OUT
  } state_t;

  // Bits needed for a counter that runs 0..n-1 (never narrower than one bit).
  // Used for the byte and bit counters of the message and digest.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sha256_serial_host_if.sv
// Byte streams and serial pins between the system/bench and the serial host.
// slave: the host itself; master: whoever drives the message and the core.
interface sha256_serial_host_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       ser_out;
  logic       ser_frame;
  logic       ser_in;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       error;

  modport slave (
    input  in_data, in_valid, ser_in, out_ready,
    output in_ready, ser_out, ser_frame, out_data, out_valid, busy, error
  );

  modport master (
    output in_data, in_valid, ser_in, out_ready,
    input  in_ready, ser_out, ser_frame, out_data, out_valid, busy, error
  );

endinterface

// File: rtl/sha256_bit_timer.sv
// Bit-time generator: tick marks the last clock of a bit-time, mid marks the
// clock on which an incoming bit is sampled (count == BIT_DIV/2).
// restart zeroes the phase so the next clock is clock 0 of a new bit-time.
module sha256_bit_timer
  import sha256_serial_pkg::*;
#(
  parameter int BIT_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick,
  output logic mid
);

  localparam int W = cnt_w(BIT_DIV);
  localparam logic [W-1:0] LAST = W'(BIT_DIV - 1);
  localparam logic [W-1:0] MID  = W'(BIT_DIV / 2);

  logic [W-1:0] cnt_reg;

  // Free-running modulo-BIT_DIV phase counter, re-aligned by restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (restart || cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = (cnt_reg == LAST);
  assign mid  = (cnt_reg == MID);

endmodule

// File: rtl/sha256_serial_host.sv
// Host-side serial link partner for the bit-serial SHA-256 core.
// Loads a message block from a byte stream, shifts it out MSB-first with a
// frame strobe, waits for the core's start bit, shifts in the digest and
// returns it as a byte stream.
// Optional watchdog on the digest wait: define SHA_HOST_TIMEOUT_EN.
module sha256_serial_host
  import sha256_serial_pkg::*;
#(
  parameter int MSG_BYTES      = SHA256_BLOCK_BITS / 8,
  parameter int DIG_BYTES      = SHA256_DIGEST_BITS / 8,
  parameter int BIT_DIV        = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 reset,
  sha256_serial_host_if.slave  bus
);

  localparam int MSG_BITS = MSG_BYTES * 8;
  localparam int DIG_BITS = DIG_BYTES * 8;
  localparam int CW       = cnt_w(MSG_BITS);

  localparam logic [CW-1:0] LAST_LOAD = CW'(MSG_BYTES - 1);
  localparam logic [CW-1:0] LAST_SEND = CW'(MSG_BITS - 1);
  localparam logic [CW-1:0] LAST_RECV = CW'(DIG_BITS - 1);
  localparam logic [CW-1:0] LAST_OUT  = CW'(DIG_BYTES - 1);

  state_t              state_reg, state_next;
  logic [MSG_BITS-1:0] sr_reg;
  logic [MSG_BITS-1:0] load_shift;
  logic [CW-1:0]       cnt_reg;
  logic                ser_out_reg;
  logic                frame_reg;
  logic                in_ready;
  logic                in_fire;
  logic                out_fire;
  logic                restart;
  logic                tick;
  logic                mid;
  logic                timeout;

  assign in_ready   = (state_reg == IDLE) || (state_reg == LOAD);
  assign in_fire    = in_ready && bus.in_valid;
  assign out_fire   = (state_reg == OUT) && bus.out_ready;
  assign load_shift = {sr_reg[MSG_BITS-9:0], bus.in_data};

  // Bit phase restarts when entering SEND or WAIT; RECV keeps the WAIT phase
  // so data bits stay aligned to the start bit.
  assign restart = (state_next != state_reg) &&
                   ((state_next == SEND) || (state_next == WAIT));

  sha256_bit_timer #(.BIT_DIV(BIT_DIV)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick),
    .mid     (mid)
  );

`ifdef SHA_HOST_TIMEOUT_EN
  localparam int TW = cnt_w(TIMEOUT_CYCLES);

  logic [TW-1:0] wait_cnt_reg;
  logic          error_reg;

  // Clocks spent in WAIT; zero on every other state so each wait starts fresh.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == WAIT) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end else begin
      wait_cnt_reg <= '0;
    end
  end

  assign timeout = (state_reg == WAIT) && (wait_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

  // Sticky timeout flag, cleared by the next accepted message byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error_reg <= 1'b0;
    end else if (timeout && !(mid && bus.ser_in)) begin
      error_reg <= 1'b1;
    end else if (in_fire) begin
      error_reg <= 1'b0;
    end
  end

  assign bus.error = error_reg;
`else
  // Without the watchdog WAIT never gives up; the timeout limit has no
  // meaning here and error is a constant 0.
  assign timeout   = 1'b0;
  assign bus.error = (TIMEOUT_CYCLES < 0);
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a start bit wins over a simultaneous timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, LOAD: if (in_fire) state_next = (cnt_reg == LAST_LOAD) ? SEND : LOAD;
      SEND:       if (tick && cnt_reg == LAST_SEND) state_next = WAIT;
      WAIT: begin
        if (mid && bus.ser_in) begin
          state_next = RECV;
        end else if (timeout) begin
          state_next = IDLE;
        end
      end
      RECV:       if (mid && cnt_reg == LAST_RECV) state_next = OUT;
      OUT:        if (out_fire && cnt_reg == LAST_OUT) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Datapath: one shift register for message and digest, one shared counter
  // (bytes in LOAD/OUT, bits in SEND/RECV), registered serial outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_reg      <= '0;
      cnt_reg     <= '0;
      ser_out_reg <= 1'b0;
      frame_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, LOAD: begin
          if (in_fire) begin
            if (cnt_reg == LAST_LOAD) begin
              // Bit 0 goes on the wire in the first SEND cycle.
              ser_out_reg <= load_shift[MSG_BITS-1];
              sr_reg      <= {load_shift[MSG_BITS-2:0], 1'b0};
              frame_reg   <= 1'b1;
              cnt_reg     <= '0;
            end else begin
              sr_reg  <= load_shift;
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        SEND: begin
          if (tick) begin
            if (cnt_reg == LAST_SEND) begin
              frame_reg   <= 1'b0;
              ser_out_reg <= 1'b0;
              cnt_reg     <= '0;
            end else begin
              ser_out_reg <= sr_reg[MSG_BITS-1];
              sr_reg      <= {sr_reg[MSG_BITS-2:0], 1'b0};
              cnt_reg     <= cnt_reg + 1'b1;
            end
          end
        end
        RECV: begin
          if (mid) begin
            sr_reg[DIG_BITS-1:0] <= {sr_reg[DIG_BITS-2:0], bus.ser_in};
            cnt_reg              <= (cnt_reg == LAST_RECV) ? '0 : cnt_reg + 1'b1;
          end
        end
        OUT: begin
          if (out_fire) begin
            sr_reg[DIG_BITS-1:0] <= {sr_reg[DIG_BITS-9:0], 8'h00};
            cnt_reg              <= (cnt_reg == LAST_OUT) ? '0 : cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.ser_out   = ser_out_reg;
  assign bus.ser_frame = frame_reg;
  assign bus.out_valid = (state_reg == OUT);
  assign bus.out_data  = (state_reg == OUT) ? sr_reg[DIG_BITS-1 -: 8] : 8'h00;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_sha256_serial_host.sv
// Directed bench for sha256_serial_host: two instances (BIT_DIV=1 and 4),
// a loopback core model returning known SHA-256 digests, stalled and
// back-to-back transfers, reset mid-send and the optional WAIT timeout.
module tb_sha256_serial_host;

  localparam int BOUND   = 20000;
  localparam int TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       ser_in_drv = 1'b0;
  int         sel = 1;

  int vectors = 0;
  int miscompares = 0;

  logic [511:0] blk [2];
  logic [255:0] dig [2];
  time          last_out_time = 0;
  time          first_hs_time = 0;

  always #5 clk = ~clk;

  sha256_serial_host_if bus1 ();
  sha256_serial_host_if bus4 ();

  assign bus1.in_data   = in_data;
  assign bus4.in_data   = in_data;
  assign bus1.in_valid  = in_valid && (sel == 1);
  assign bus4.in_valid  = in_valid && (sel == 4);
  assign bus1.out_ready = out_ready && (sel == 1);
  assign bus4.out_ready = out_ready && (sel == 4);
  assign bus1.ser_in    = ser_in_drv && (sel == 1);
  assign bus4.ser_in    = ser_in_drv && (sel == 4);

  wire       o_in_ready  = (sel == 4) ? bus4.in_ready  : bus1.in_ready;
  wire       o_ser_out   = (sel == 4) ? bus4.ser_out   : bus1.ser_out;
  wire       o_ser_frame = (sel == 4) ? bus4.ser_frame : bus1.ser_frame;
  wire [7:0] o_out_data  = (sel == 4) ? bus4.out_data  : bus1.out_data;
  wire       o_out_valid = (sel == 4) ? bus4.out_valid : bus1.out_valid;
  wire       o_busy      = (sel == 4) ? bus4.busy      : bus1.busy;
  wire       o_error     = (sel == 4) ? bus4.error     : bus1.error;

  sha256_serial_host #(.MSG_BYTES(64), .DIG_BYTES(32), .BIT_DIV(1), .TIMEOUT_CYCLES(TIMEOUT)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  sha256_serial_host #(.MSG_BYTES(64), .DIG_BYTES(32), .BIT_DIV(4), .TIMEOUT_CYCLES(TIMEOUT)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  // Feed the 64 bytes of block b; optionally keep in_valid high afterwards.
  task automatic feed(input int b, input bit drop_valid);
    int  n;
    bit  acc;
    for (int i = 0; i < 64; i++) begin
      n = 0;
      acc = 1'b0;
      in_data  = blk[b][511-8*i -: 8];
      in_valid = 1'b1;
      while (!acc && n < BOUND) begin
        acc = o_in_ready;
        if (acc && i == 0) first_hs_time = $time;
        @(negedge clk);
        n++;
      end
      if (!acc) begin
        vectors++; miscompares++;
        $display("FAIL feed_timeout block=%0d byte=%0d in_ready never seen, required 1", b, i);
        in_valid = 1'b0;
        return;
      end
    end
    if (drop_valid) in_valid = 1'b0;
    vectors++;
    if ({o_ser_frame, o_in_ready, o_ser_out} !== {1'b1, 1'b0, blk[b][511]}) begin
      miscompares++;
      $display("FAIL send_start block=%0d frame/in_ready/ser_out=%b%b%b required 10%b",
               b, o_ser_frame, o_in_ready, o_ser_out, blk[b][511]);
    end
  endtask

  // Core loopback model: capture the frame, check it, answer with the digest
  // of the recognised block. Non-mid clocks of each digest bit carry the
  // inverted bit so only a correctly placed sample recovers the digest.
  task automatic core_model(input int b, input int d, input int lat);
    int           n;
    int           cnt;
    int           idx;
    int           hold_err;
    logic [511:0] cap;
    logic [255:0] resp;
    logic         bitv;
    n = 0; cnt = 0; hold_err = 0; cap = '0;
    while (o_ser_frame !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= BOUND) begin
      miscompares++;
      $display("FAIL frame_start block=%0d ser_frame never rose, required 1", b);
      return;
    end
    while (o_ser_frame === 1'b1 && cnt < 512 * d + 8) begin
      idx = cnt / d;
      if (cnt % d == 0) begin
        if (idx < 512) cap[511-idx] = o_ser_out;
      end else if (idx < 512 && o_ser_out !== cap[511-idx]) begin
        hold_err++;
      end
      cnt++;
      @(negedge clk);
    end
    vectors++;
    if (cnt != 512 * d) begin
      miscompares++;
      $display("FAIL frame_len block=%0d got %0d clocks required %0d", b, cnt, 512 * d);
    end
    vectors++;
    if (hold_err != 0) begin
      miscompares++;
      $display("FAIL bit_hold block=%0d got %0d changes inside a bit-time required 0", b, hold_err);
    end
    vectors++;
    if (cap !== blk[b]) begin
      miscompares++;
      $display("FAIL ser_stream block=%0d got %h required %h", b, cap, blk[b]);
    end
    vectors++;
    if (o_ser_out !== 1'b0) begin
      miscompares++;
      $display("FAIL ser_out_idle block=%0d got %b required 0", b, o_ser_out);
    end
    resp = (cap == blk[0]) ? dig[0] : (cap == blk[1]) ? dig[1] : ~dig[0];
    for (int m = 0; m <= lat + 256; m++) begin
      for (int j = 0; j < d; j++) begin
        if (m < lat) begin
          ser_in_drv = 1'b0;
        end else if (m == lat) begin
          ser_in_drv = (j == d / 2);
        end else begin
          bitv = resp[255-(m-lat-1)];
          ser_in_drv = (j == d / 2) ? bitv : ~bitv;
        end
        @(negedge clk);
      end
    end
    ser_in_drv = 1'b0;
  endtask

  // Collect 32 digest bytes, optionally with random out_ready stalls.
  task automatic sink(input int b, input bit stall);
    int         k;
    int         n;
    bit         stalled;
    logic [7:0] held;
    logic [7:0] exp_byte;
    k = 0; n = 0; stalled = 1'b0; held = 8'h00;
    while (k < 32 && n < BOUND) begin
      @(negedge clk);
      n++;
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_out_valid === 1'b1) begin
        if (stalled) begin
          vectors++;
          if (o_out_data !== held) begin
            miscompares++;
            $display("FAIL out_stable block=%0d byte=%0d got %h required %h", b, k, o_out_data, held);
          end
        end
        if (out_ready) begin
          exp_byte = dig[b][255-8*k -: 8];
          vectors++;
          if (o_out_data !== exp_byte) begin
            miscompares++;
            $display("FAIL out_byte block=%0d byte=%0d got %h required %h", b, k, o_out_data, exp_byte);
          end
          k++;
          stalled = 1'b0;
          last_out_time = $time;
        end else begin
          held = o_out_data;
          stalled = 1'b1;
        end
      end
    end
    vectors++;
    if (k < 32) begin
      miscompares++;
      $display("FAIL out_timeout block=%0d got %0d bytes required 32", b, k);
      return;
    end
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if ({o_out_valid, o_in_ready, o_busy} !== 3'b010) begin
      miscompares++;
      $display("FAIL out_done block=%0d out_valid/in_ready/busy=%b%b%b required 010",
               b, o_out_valid, o_in_ready, o_busy);
    end
    $display("block %0d: digest %h returned on instance BIT_DIV=%0d", b, dig[b], sel);
  endtask

  task automatic run_block(input int b, input int d, input int lat, input bit stall);
    sel = d;
    @(negedge clk);
    fork
      feed(b, 1'b1);
      core_model(b, d, lat);
      sink(b, stall);
    join
  endtask

  task automatic test_reset();
    for (int s = 1; s <= 4; s += 3) begin
      for (int ph = 0; ph < 2; ph++) begin
        sel = s;
        #1;
        vectors++;
        if ({o_in_ready, o_ser_out, o_ser_frame, o_out_valid, o_busy, o_error, o_out_data} !== 14'b10000000000000) begin
          miscompares++;
          $display("FAIL reset_values sel=%0d phase=%0d got %b%b%b%b%b%b_%h required 100000_00",
                   s, ph, o_in_ready, o_ser_out, o_ser_frame, o_out_valid, o_busy, o_error, o_out_data);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
      end
    end
    $display("reset: both instances checked");
  endtask

  task automatic test_abc_div1();
    run_block(0, 1, 3, 1'b0);
  endtask

  task automatic test_abc_div4();
    run_block(0, 4, 2, 1'b0);
  endtask

  task automatic test_out_stall();
    run_block(1, 1, 3, 1'b1);
  endtask

  task automatic test_reset_mid_send();
    int n;
    sel = 1;
    @(negedge clk);
    n = 0;
    fork
      feed(0, 1'b1);
      begin
        while (o_ser_frame !== 1'b1 && n < BOUND) begin
          @(negedge clk);
          n++;
        end
        repeat (200) @(negedge clk);
      end
    join
    vectors++;
    if ({o_busy, o_ser_frame} !== 2'b11) begin
      miscompares++;
      $display("FAIL pre_reset_send busy/frame=%b%b required 11", o_busy, o_ser_frame);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({o_ser_frame, o_in_ready, o_busy} !== 3'b010) begin
      miscompares++;
      $display("FAIL reset_abort frame/in_ready/busy=%b%b%b required 010", o_ser_frame, o_in_ready, o_busy);
    end
    reset = 1'b0;
    $display("reset at bit 200 of SEND: aborted");
    run_block(0, 1, 4, 1'b0);
  endtask

  task automatic test_back_to_back();
    time out_done_time;
    sel = 1;
    out_done_time = 0;
    @(negedge clk);
    fork
      begin feed(0, 1'b0); feed(1, 1'b1); end
      begin core_model(0, 1, 5); core_model(1, 1, 2); end
      begin sink(0, 1'b0); out_done_time = last_out_time; sink(1, 1'b1); end
    join
    vectors++;
    if (first_hs_time <= out_done_time) begin
      miscompares++;
      $display("FAIL b2b_order second block accepted at %0t, required after %0t", first_hs_time, out_done_time);
    end
  endtask

  task automatic test_timeout();
    int n;
    sel = 1;
    @(negedge clk);
    feed(0, 1'b1);
    n = 0;
    while (o_ser_frame === 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
`ifdef SHA_HOST_TIMEOUT_EN
    repeat (TIMEOUT - 1) @(negedge clk);
    vectors++;
    if ({o_busy, o_error} !== 2'b10) begin
      miscompares++;
      $display("FAIL pre_timeout busy/error=%b%b required 10", o_busy, o_error);
    end
    @(negedge clk);
    vectors++;
    if ({o_error, o_busy, o_in_ready} !== 3'b101) begin
      miscompares++;
      $display("FAIL timeout error/busy/in_ready=%b%b%b required 101", o_error, o_busy, o_in_ready);
    end
    in_data = 8'h61;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if ({o_error, o_busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL error_clear error/busy=%b%b required 01", o_error, o_busy);
    end
    $display("timeout: error raised after %0d WAIT clocks and cleared", TIMEOUT);
`else
    repeat (3 * TIMEOUT) @(negedge clk);
    vectors++;
    if ({o_busy, o_error, o_in_ready} !== 3'b100) begin
      miscompares++;
      $display("FAIL wait_forever busy/error/in_ready=%b%b%b required 100", o_busy, o_error, o_in_ready);
    end
    $display("no timeout: still waiting after %0d clocks", 3 * TIMEOUT);
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    blk[0] = '0;
    blk[0][511:480] = 32'h61626380;
    blk[0][7:0]     = 8'h18;
    blk[1] = '0;
    blk[1][511:504] = 8'h80;
    dig[0] = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    dig[1] = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

    @(negedge clk);
    test_reset();
    test_abc_div1();
    test_abc_div4();
    test_out_stall();
    test_reset_mid_send();
    test_back_to_back();
    test_timeout();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
